// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: branch history/target table with mispredict recovery.
//
// Ports:
//   clock, reset            core clock (rising edge), async active-low reset
//   if_pc                   fetch PC, looked up combinationally
//   if_predict_taken/target combinational prediction for if_pc
//   ex_*                    resolved branch from EX plus the prediction it carried
//   redirect, redirect_pc   registered one-cycle PC redirect
//   flush_if_id/id_ex       registered flush pulses, equal to redirect
//   stat_branches/mispredicts  saturating counters, present only with
//                              BRANCH_STATS_EN defined
//
// Optional feature macro: BRANCH_STATS_EN
module branch_predict_ctrl #(
    parameter int unsigned IDX_BITS = 6,
    parameter int unsigned TAG_BITS = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] if_pc,
    output logic        if_predict_taken,
    output logic [31:0] if_predict_target,
    input  logic        ex_valid,
    input  logic        ex_branch,
    input  logic        ex_taken,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush_if_id,
    output logic        flush_id_ex
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;
    localparam int unsigned TAG_LO  = IDX_BITS + 2;
    localparam int unsigned TAG_HI  = IDX_BITS + TAG_BITS + 1;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_RECOVER = 1'b1
    } state_e;

    // Table storage
    logic                valid_q  [ENTRIES];
    logic                valid_d  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [TAG_BITS-1:0] tag_d    [ENTRIES];
    logic [31:0]         target_q [ENTRIES];
    logic [31:0]         target_d [ENTRIES];
    logic [1:0]          ctr_q    [ENTRIES];
    logic [1:0]          ctr_d    [ENTRIES];

    state_e      state_q, state_d;
    logic        redirect_q, redirect_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic [IDX_BITS-1:0] if_idx, ex_idx;
    logic [TAG_BITS-1:0] if_tag, ex_tag;
    logic                if_hit, ex_hit;
    logic                res, mispredict;
    logic [31:0]         recover_pc;

    assign if_idx = if_pc[TAG_LO-1:2];
    assign if_tag = if_pc[TAG_HI:TAG_LO];
    assign ex_idx = ex_pc[TAG_LO-1:2];
    assign ex_tag = ex_pc[TAG_HI:TAG_LO];

    // Address bits outside index/tag do not take part in the lookup
    logic unused_if_bits;
    assign unused_if_bits = ^{if_pc[1:0], if_pc[31:TAG_HI+1]};

    // Fetch-side lookup; reads pre-update contents (no bypass)
    assign if_hit            = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign if_predict_taken  = if_hit && ctr_q[if_idx][1];
    assign if_predict_target = if_hit ? target_q[if_idx] : 32'd0;

    // Resolution is gated while redirecting: the EX instruction is wrong-path
    assign res        = ex_valid && ex_branch && !redirect_q;
    assign mispredict = (ex_taken != ex_pred_taken) ||
                        (ex_taken && ex_pred_taken && (ex_target != ex_pred_target));
    assign recover_pc = ex_taken ? ex_target : (ex_pc + 32'd4);
    assign ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    // Table training
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (res) begin
            if (ex_hit) begin
                if (ex_taken) begin
                    ctr_d[ex_idx]    = (ctr_q[ex_idx] == 2'd3) ? 2'd3 : ctr_q[ex_idx] + 2'd1;
                    target_d[ex_idx] = ex_target;
                end else begin
                    ctr_d[ex_idx]    = (ctr_q[ex_idx] == 2'd0) ? 2'd0 : ctr_q[ex_idx] - 2'd1;
                end
            end else if (ex_taken) begin
                valid_d[ex_idx]  = 1'b1;
                tag_d[ex_idx]    = ex_tag;
                target_d[ex_idx] = ex_target;
                ctr_d[ex_idx]    = 2'd2;
            end
        end
    end

    // Recovery FSM next state and outputs
    always_comb begin
        state_d       = state_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        case (state_q)
            S_IDLE: begin
                if (res && mispredict) begin
                    state_d       = S_RECOVER;
                    redirect_d    = 1'b1;
                    redirect_pc_d = recover_pc;
                end
            end
            S_RECOVER: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and table registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'd0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                ctr_q[i]    <= 2'b01;
            end
        end else begin
            state_q       <= state_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            valid_q       <= valid_d;
            tag_q         <= tag_d;
            target_q      <= target_d;
            ctr_q         <= ctr_d;
        end
    end

    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign flush_if_id = redirect_q;
    assign flush_id_ex = redirect_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    // Saturating event counters
    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (res && (stat_branches_q != 32'hFFFF_FFFF)) begin
            stat_branches_d = stat_branches_q + 32'd1;
        end
        if (res && mispredict && (stat_mispredicts_q != 32'hFFFF_FFFF)) begin
            stat_mispredicts_d = stat_mispredicts_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_branches_q    <= 32'd0;
            stat_mispredicts_q <= 32'd0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: redirect expectations are
// queued as EX stimulus is driven and popped after the following edge.
module tb_branch_predict_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic        if_predict_taken;
    logic [31:0] if_predict_target;
    logic        ex_valid, ex_branch, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush_if_id, flush_id_ex;
`ifdef BRANCH_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    branch_predict_ctrl dut (
        .clock             (clock),
        .reset             (reset),
        .if_pc             (if_pc),
        .if_predict_taken  (if_predict_taken),
        .if_predict_target (if_predict_target),
        .ex_valid          (ex_valid),
        .ex_branch         (ex_branch),
        .ex_taken          (ex_taken),
        .ex_pc             (ex_pc),
        .ex_target         (ex_target),
        .ex_pred_taken     (ex_pred_taken),
        .ex_pred_target    (ex_pred_target),
        .redirect          (redirect),
        .redirect_pc       (redirect_pc),
        .flush_if_id       (flush_if_id),
        .flush_id_ex       (flush_id_ex)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches     (stat_branches),
        .stat_mispredicts  (stat_mispredicts)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        redir;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          passed = 0;
    int          total  = 0;
    logic        m_redir;
    logic [31:0] m_pc;
    int          m_br, m_mis;

    task automatic model_reset();
        m_redir = 1'b0;
        m_pc    = 32'd0;
        m_br    = 0;
        m_mis   = 0;
        sb.delete();
    endtask

    // Drive one EX slot and queue the redirect state expected after the edge
    task automatic drive_ex(input logic v, input logic b, input logic t,
                            input logic [31:0] pc, input logic [31:0] tgt,
                            input logic pt, input logic [31:0] ptgt);
        logic res, mis;
        exp_t x;
        ex_valid       = v;
        ex_branch      = b;
        ex_taken       = t;
        ex_pc          = pc;
        ex_target      = tgt;
        ex_pred_taken  = pt;
        ex_pred_target = ptgt;
        res = v && b && !m_redir;
        mis = res && ((t != pt) || (t && pt && (tgt != ptgt)));
        if (res) m_br++;
        if (mis) begin
            m_mis++;
            m_pc = t ? tgt : pc + 32'd4;
        end
        m_redir = mis;
        x.redir = mis;
        x.pc    = m_pc;
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        if_pc = 32'h100;
        drive_ex(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        void'(sb.pop_front());
        #12;
        total++;
        if (if_predict_taken !== 1'b0 || if_predict_target !== 32'd0 || redirect !== 1'b0 ||
            redirect_pc !== 32'd0 || flush_if_id !== 1'b0 || flush_id_ex !== 1'b0)
            $display("FAIL reset_state: pt=%b tgt=%h redir=%b rpc=%h fl=%b%b, required all 0",
                     if_predict_taken, if_predict_target, redirect, redirect_pc,
                     flush_if_id, flush_id_ex);
        else passed++;
`ifdef BRANCH_STATS_EN
        total++;
        if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0)
            $display("FAIL reset_stats: br=%0d mis=%0d, required 0/0", stat_branches, stat_mispredicts);
        else passed++;
`endif
        #2 reset = 1'b1;
    endtask

    task automatic test_first_taken();
        drive_ex(1'b1, 1'b1, 1'b1, 32'h100, 32'h80, 1'b0, 32'd0);
        tick();
        e = sb.pop_front();
        total++;
        if (redirect !== e.redir || redirect_pc !== e.pc || flush_if_id !== e.redir || flush_id_ex !== e.redir)
            $display("FAIL first_redirect: redir=%b pc=%h fl=%b%b, required %b %h", redirect,
                     redirect_pc, flush_if_id, flush_id_ex, e.redir, e.pc);
        else passed++;
        drive_ex(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        if_pc = 32'h100;
        #1;
        total++;
        if (if_predict_taken !== 1'b1 || if_predict_target !== 32'h80)
            $display("FAIL first_alloc: pt=%b tgt=%h, required 1 00000080", if_predict_taken, if_predict_target);
        else passed++;
        tick();
        e = sb.pop_front();
        total++;
        if (redirect !== e.redir || redirect_pc !== e.pc || flush_if_id !== e.redir)
            $display("FAIL first_release: redir=%b pc=%h, required %b %h", redirect, redirect_pc, e.redir, e.pc);
        else passed++;
    endtask

    task automatic test_not_taken_training();
        drive_ex(1'b1, 1'b1, 1'b0, 32'h100, 32'h80, 1'b1, 32'h80);
        tick();
        e = sb.pop_front();
        total++;
        if (redirect !== e.redir || redirect_pc !== e.pc || flush_id_ex !== e.redir)
            $display("FAIL nt_redirect: redir=%b pc=%h, required %b %h", redirect, redirect_pc, e.redir, e.pc);
        else passed++;
        total++;
        if (if_predict_taken !== 1'b0 || if_predict_target !== 32'h80)
            $display("FAIL nt_ctr1: pt=%b tgt=%h, required 0 00000080", if_predict_taken, if_predict_target);
        else passed++;
        drive_ex(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        tick();
        void'(sb.pop_front());
        // Correctly predicted not-taken: no redirect, counter down to 0
        drive_ex(1'b1, 1'b1, 1'b0, 32'h100, 32'h80, 1'b0, 32'd0);
        tick();
        e = sb.pop_front();
        total++;
        if (redirect !== e.redir || redirect_pc !== e.pc)
            $display("FAIL nt_repeat: redir=%b pc=%h, required %b %h", redirect, redirect_pc, e.redir, e.pc);
        else passed++;
        total++;
        if (if_predict_taken !== 1'b0)
            $display("FAIL nt_ctr0: pt=%b, required 0", if_predict_taken);
        else passed++;
    endtask

    task automatic test_wrong_target();
        drive_ex(1'b1, 1'b1, 1'b1, 32'h100, 32'h90, 1'b1, 32'h80);
        tick();
        e = sb.pop_front();
        total++;
        if (redirect !== e.redir || redirect_pc !== e.pc || flush_if_id !== e.redir)
            $display("FAIL wt_redirect: redir=%b pc=%h, required %b %h", redirect, redirect_pc, e.redir, e.pc);
        else passed++;
        // Counter 0 -> 1: still weakly not-taken, target retrained
        total++;
        if (if_predict_taken !== 1'b0 || if_predict_target !== 32'h90)
            $display("FAIL wt_entry: pt=%b tgt=%h, required 0 00000090", if_predict_taken, if_predict_target);
        else passed++;
        drive_ex(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        tick();
        void'(sb.pop_front());
        drive_ex(1'b1, 1'b1, 1'b1, 32'h100, 32'h90, 1'b1, 32'h90);
        tick();
        e = sb.pop_front();
        total++;
        if (redirect !== e.redir || redirect_pc !== e.pc)
            $display("FAIL wt_correct: redir=%b pc=%h, required %b %h", redirect, redirect_pc, e.redir, e.pc);
        else passed++;
        total++;
        if (if_predict_taken !== 1'b1 || if_predict_target !== 32'h90)
            $display("FAIL wt_ctr2: pt=%b tgt=%h, required 1 00000090", if_predict_taken, if_predict_target);
        else passed++;
    endtask

    task automatic test_back_to_back_recover();
        drive_ex(1'b1, 1'b1, 1'b1, 32'h180, 32'h40, 1'b0, 32'd0);
        if_pc = 32'h180;
        #1;
        total++;
        if (if_predict_taken !== 1'b0 || if_predict_target !== 32'd0)
            $display("FAIL no_bypass: pt=%b tgt=%h, required 0 00000000", if_predict_taken, if_predict_target);
        else passed++;
        tick();
        e = sb.pop_front();
        total++;
        if (redirect !== e.redir || redirect_pc !== e.pc)
            $display("FAIL b2b_first: redir=%b pc=%h, required %b %h", redirect, redirect_pc, e.redir, e.pc);
        else passed++;
        // Wrong-path mispredicting branch during RECOVER must be ignored
        drive_ex(1'b1, 1'b1, 1'b1, 32'h204, 32'h500, 1'b0, 32'd0);
        tick();
        e = sb.pop_front();
        total++;
        if (redirect !== e.redir || redirect_pc !== e.pc || flush_if_id !== e.redir)
            $display("FAIL b2b_ignored: redir=%b pc=%h, required %b %h", redirect, redirect_pc, e.redir, e.pc);
        else passed++;
        drive_ex(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        if_pc = 32'h204;
        #1;
        total++;
        if (if_predict_taken !== 1'b0 || if_predict_target !== 32'd0)
            $display("FAIL b2b_no_alloc: pt=%b tgt=%h, required 0 00000000", if_predict_taken, if_predict_target);
        else passed++;
        if_pc = 32'h180;
        #1;
        total++;
        if (if_predict_taken !== 1'b1 || if_predict_target !== 32'h40)
            $display("FAIL b2b_alloc: pt=%b tgt=%h, required 1 00000040", if_predict_taken, if_predict_target);
        else passed++;
        tick();
        void'(sb.pop_front());
`ifdef BRANCH_STATS_EN
        total++;
        if (stat_branches !== 32'(m_br) || stat_mispredicts !== 32'(m_mis))
            $display("FAIL stats: br=%0d mis=%0d, required %0d %0d", stat_branches, stat_mispredicts, m_br, m_mis);
        else passed++;
`endif
    endtask

    task automatic test_pc_wrap();
        drive_ex(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h1234, 1'b1, 32'h1234);
        tick();
        e = sb.pop_front();
        total++;
        if (redirect !== e.redir || redirect_pc !== e.pc)
            $display("FAIL wrap_redirect: redir=%b pc=%h, required %b %h", redirect, redirect_pc, e.redir, e.pc);
        else passed++;
        drive_ex(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        if_pc = 32'hFFFF_FFFC;
        tick();
        e = sb.pop_front();
        total++;
        if (redirect !== e.redir || if_predict_taken !== 1'b0)
            $display("FAIL wrap_release: redir=%b pt=%b, required %b 0", redirect, if_predict_taken, e.redir);
        else passed++;
    endtask

    task automatic test_reset_mid_recover();
        drive_ex(1'b1, 1'b1, 1'b1, 32'h300, 32'h44, 1'b0, 32'd0);
        tick();
        e = sb.pop_front();
        total++;
        if (redirect !== e.redir || redirect_pc !== e.pc)
            $display("FAIL mid_redirect: redir=%b pc=%h, required %b %h", redirect, redirect_pc, e.redir, e.pc);
        else passed++;
        drive_ex(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        reset = 1'b0;
        model_reset();
        if_pc = 32'h180;
        #1;
        total++;
        if (redirect !== 1'b0 || flush_if_id !== 1'b0 || flush_id_ex !== 1'b0 || redirect_pc !== 32'd0)
            $display("FAIL mid_abort: redir=%b fl=%b%b pc=%h, required 0 00 00000000", redirect,
                     flush_if_id, flush_id_ex, redirect_pc);
        else passed++;
        total++;
        if (if_predict_taken !== 1'b0 || if_predict_target !== 32'd0)
            $display("FAIL mid_table_clear: pt=%b tgt=%h, required 0 00000000", if_predict_taken, if_predict_target);
        else passed++;
        #2 reset = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        tick();
        test_first_taken();
        test_not_taken_training();
        test_wrong_target();
        test_back_to_back_recover();
        test_pc_wrap();
        test_reset_mid_recover();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Safety bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
